// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_pkg;

  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_master_state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request channel to APB3 SETUP/ACCESS transfer, one outstanding at a time.
// Optional ACCESS-phase abort on a stuck slave when APB_TIMEOUT_EN is defined.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int addrWidth      = ADDR_WIDTH_DEF,
  parameter int dataWidth      = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [addrWidth-1:0] req_addr,
  input  logic                 req_write,
  input  logic [dataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic [addrWidth-1:0] paddr,
  output logic                 pwrite,
  output logic [dataWidth-1:0] pwdata,
  input  logic                 pready,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pslverr,
  output logic                 busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  apb_master_state_e state_reg;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_reg;
`endif

  assign busy      = (state_reg != IDLE);
  assign req_ready = (state_reg == IDLE) && (!rsp_valid || rsp_ready);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      // A completion below overrides this drain; acceptance guarantees the slot is free by then.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            paddr     <= req_addr;
            pwrite    <= req_write;
            pwdata    <= req_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            assert (!rsp_valid) else $error("completion while a response is still pending");
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_reg <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt_reg == WAIT_LIMIT) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        default: begin
          state_reg <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: directed vector table, back-pressure/reset/timeout sequences, random traffic.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;
  logic          busy;

  apb_master_bridge #(
    .addrWidth     (AW),
    .dataWidth     (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .busy     (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    bit            write;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    bit            err;
    int            hold;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
  } exp_rsp_t;

  exp_rsp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Reference rule: reads return the slave's data, writes return zero; error mirrors pslverr.
  function automatic exp_rsp_t model(input vec_t v);
    exp_rsp_t r;
    r.rdata = v.write ? '0 : v.rdata;
    r.err   = v.err;
    return r;
  endfunction

  task automatic run_xfer(input vec_t v, input bit drain);
    exp_rsp_t e;
    int guard;
    logic [DW-1:0] held_rdata;
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      step();
      guard++;
    end
    check("req_ready_timeout", 64'(guard < 20), 64'd1);
    step();
    exp_q.push_back(model(v));
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = ~v.write;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, v.addr);
    check("setup_pwrite", pwrite, v.write);
    check("setup_pwdata", pwdata, v.wdata);
    check("setup_busy", busy, 1);
    check("setup_req_ready", req_ready, 0);
    step();
    check("access_penable", penable, 1);
    for (int w = 0; w < v.waits; w++) begin
      pready  = 1'b0;
      prdata  = 'x;
      pslverr = 1'bx;
      step();
      check("wait_psel_penable", {psel, penable}, 2'b11);
      check("wait_paddr", paddr, v.addr);
      check("wait_pwrite", pwrite, v.write);
      check("wait_rsp_valid", rsp_valid, 0);
    end
    pready  = 1'b1;
    prdata  = v.rdata;
    pslverr = v.err;
    step();
    pready  = 1'b0;
    prdata  = 'x;
    pslverr = 1'bx;
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_err", rsp_err, e.err);
    check("done_psel_penable", {psel, penable}, 2'b00);
    check("done_busy", busy, 0);
    held_rdata = rsp_rdata;
    $display("xfer %0d: %s addr=0x%08h wdata=0x%08h waits=%0d -> rdata=0x%08h err=%0d",
             n_xfer, v.write ? "WR" : "RD", v.addr, v.wdata, v.waits, rsp_rdata, rsp_err);
    n_xfer++;
    for (int h = 0; h < v.hold; h++) begin
      step();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, held_rdata);
      check("hold_rsp_err", rsp_err, e.err);
      check("hold_req_ready", req_ready, 0);
    end
    if (drain) begin
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check("drain_rsp_valid", rsp_valid, 0);
    end
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;

    vecs[0] = '{addr: 32'h10,  write: 1'b1, wdata: 32'hA5A5_0001, waits: 0, rdata: 32'h1234_5678, err: 1'b0, hold: 0};
    vecs[1] = '{addr: 32'h24,  write: 1'b0, wdata: 32'h0,         waits: 3, rdata: 32'hDEAD_BEEF, err: 1'b0, hold: 1};
    vecs[2] = '{addr: 32'h400, write: 1'b0, wdata: 32'h0,         waits: 0, rdata: 32'h0BAD_0BAD, err: 1'b1, hold: 0};
    vecs[3] = '{addr: 32'h404, write: 1'b1, wdata: 32'hFFFF_0000, waits: 2, rdata: 32'hCAFE_F00D, err: 1'b1, hold: 2};

    step();
    step();
    rst = 1'b0;
    check("reset_psel", psel, 0);
    check("reset_penable", penable, 0);
    check("reset_pwrite", pwrite, 0);
    check("reset_paddr", paddr, 0);
    check("reset_pwdata", pwdata, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 1);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i], 1'b1);

    // Back-pressure: response held for 5 cycles, next request taken on the draining cycle.
    v = '{addr: 32'h50, write: 1'b0, wdata: 32'h0, waits: 1, rdata: 32'h7777_1111, err: 1'b0, hold: 5};
    run_xfer(v, 1'b0);
    req_valid = 1'b1; req_addr = 32'h60; req_write = 1'b1; req_wdata = 32'h0000_BEEF;
    #1;
    check("bp_req_ready_blocked", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    check("bp_req_ready_drain", req_ready, 1);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("bp_second_psel", psel, 1);
    check("bp_second_paddr", paddr, 32'h60);
    check("bp_old_rsp_gone", rsp_valid, 0);
    step();
    pready = 1'b1;
    step();
    pready = 1'b0;
    check("bp_second_rsp_valid", rsp_valid, 1);
    check("bp_second_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while waiting in ACCESS.
    req_valid = 1'b1; req_addr = 32'h88; req_write = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    check("pre_reset_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_penable", penable, 0);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_paddr", paddr, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      v.addr  = $urandom;
      v.write = 1'($urandom_range(0, 1));
      v.wdata = $urandom;
      v.waits = int'($urandom_range(0, 4));
      v.rdata = $urandom;
      v.err   = 1'($urandom_range(0, 1));
      v.hold  = int'($urandom_range(0, 3));
      run_xfer(v, 1'b1);
    end

    // Slave never answers.
    req_valid = 1'b1; req_addr = 32'h30; req_write = 1'b0;
    step();
    req_valid = 1'b0;
    pready = 1'b0;
    step();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      step();
      check("to_waiting_rsp_valid", rsp_valid, 0);
      check("to_waiting_psel", psel, 1);
    end
    step();
    check("to_abort_rsp_valid", rsp_valid, 1);
    check("to_abort_rsp_err", rsp_err, 1);
    check("to_abort_rsp_rdata", rsp_rdata, 0);
    check("to_abort_psel_penable", {psel, penable}, 2'b00);
    check("to_abort_busy", busy, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`else
    for (int i = 0; i < 100; i++) step();
    check("stuck_psel_penable", {psel, penable}, 2'b11);
    check("stuck_busy", busy, 1);
    check("stuck_rsp_valid", rsp_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB3 requester stage sitting directly upstream of the team's APB slave wrapper; drives psel/penable/paddr/pwrite/pwdata into it and consumes pready/prdata/pslverr.
- Converts a simple valid/ready request channel (one read or write per request) into a compliant SETUP→ACCESS APB transfer.
- Returns a held response (read data + error) on a valid/ready response channel.
- One outstanding transfer at a time.

Parameters:
- addrWidth, 32, width of req_addr/paddr
- dataWidth, 32, width of all data buses
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles without pready before abort (used only with APB_TIMEOUT_EN; must be ≥1)

Ports:
- pclk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at pclk edge
- req_addr  in  addrWidth  transfer address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  dataWidth  write data; ignored for reads
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  dataWidth  read data; 0 for writes
- rsp_err  out  1  slave error or timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  addrWidth  APB address
- pwrite  out  1  APB direction
- pwdata  out  dataWidth  APB write data
- pready  in  1  APB ready
- prdata  in  dataWidth  APB read data; may be X/Z unless pready=1
- pslverr  in  1  APB error; may be X/Z unless pready=1
- busy  out  1  state != IDLE

Behaviour:
- Single clock pclk; reset is synchronous and active-high (rst). While rst=1 at an edge:
  - state→IDLE
  - psel, penable, pwrite = 0; paddr, pwdata = 0
  - rsp_valid, rsp_err = 0; rsp_rdata = 0
  - any in-flight transfer or pending response is discarded.
- All APB outputs and rsp_* are registered. req_ready and busy are combinational from state and the response register.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE:
    - req_ready = !rsp_valid || rsp_ready (response slot empty or draining this cycle).
    - On request handshake: latch addr/write/wdata into paddr/pwrite/pwdata; psel=1, penable=0; →SETUP.
  - SETUP: exactly one cycle; penable=1; →ACCESS.
  - ACCESS:
    - Hold psel=1, penable=1, paddr/pwrite/pwdata stable.
    - On an edge with pready=1: rsp_rdata = pwrite ? 0 : prdata; rsp_err = pslverr; rsp_valid=1; psel=0, penable=0; →IDLE.
- prdata/pslverr are sampled only in ACCESS with pready=1; X/Z at any other time must not propagate.
- Response channel:
  - rsp_valid stays high with stable rsp_rdata/rsp_err until rsp_ready.
  - Completion and drain in the same cycle: new response wins (cannot occur with one outstanding transfer; assert it).
- Latency (zero wait states):
  - Accept at edge N → psel=1 after N, penable=1 after N+1, rsp_valid=1 after N+2.
  - Sustained throughput with rsp_ready=1: one transfer per 3 cycles.
  - Each pready=0 cycle in ACCESS adds one cycle.
- paddr and pwdata are not zeroed after a transfer; they hold their last value. Only psel qualifies them.
- Requests are never accepted while busy=1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Wait counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES with pready still 0: abort. psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, →IDLE.
  - pready=1 on the same edge as the limit is a normal completion.
- Not defined:
  - No counter logic.
  - ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum apb_master_state_e {IDLE, SETUP, ACCESS}
  - typedef struct apb_rsp_t {rdata, err}
  - default width constants.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Zero-wait write: req addr 0x10, wdata 0xA5A5_0001, pready=1 → psel at N+1, penable at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: prdata=0xDEAD_BEEF on 4th ACCESS cycle → rsp_rdata=0xDEADBEEF; paddr/pwrite stable across all ACCESS cycles; X on prdata earlier never reaches rsp.
- Slave error: addr 0x400, pslverr=1 with pready → rsp_err=1.
- Back-pressure: rsp_ready=0 for 5 cycles → rsp held stable, req_ready=0; second request accepted in the cycle rsp_ready=1.
- Reset mid-ACCESS: rst=1 one cycle → next cycle psel=0, penable=0, rsp_valid=0, busy=0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 → abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0. Without the macro, still in ACCESS at cycle 100.
